cmd_rx_parser: RTL and testbench

Byte-stream packet parser directly upstream of the triangle-draw command stage. It hunts for SYNC 0xAA, collects LEN, opcode and payload, and checks a CRC-8. For a valid CMD_DRAW_TRI packet it emits a one-cycle draw request carrying a 16-bit edge address. Every valid packet is also exposed on a generic command port, and malformed or stalled packets are reported through an error pulse.

---
 rtl/cmd_rx_parser.sv | 196 +++++++++++++++++++
 tb/tb_cmd_rx_parser.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_rx_parser.sv
// Byte-stream packet parser (SYNC 0xAA, LEN, OP, payload, CRC-8) feeding the triangle-draw stage.
// Valid packets are published on the command port; draw packets also raise a one-cycle draw request.
module cmd_rx_parser #(
    parameter int MAX_PAYLOAD    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     draw_busy,
    output logic                     draw_req_pulse,
    output logic [15:0]              edge_addr,
    output logic                     cmd_valid,
    output logic [7:0]               cmd_opcode,
    output logic [7:0]               cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     err_pulse,
    output logic [2:0]               err_code,
    output logic [2:0]               dbg_state
);
    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SYNC     = 8'hAA;
    localparam logic [7:0] OP_DRAW  = 8'h06;
    localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD + 2);
    localparam logic [2:0] ERR_CRC  = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_TMO  = 3'd3;
    localparam logic [2:0] ERR_BUSY = 3'd4;
    localparam logic [2:0] ERR_FMT  = 3'd5;

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_OP, S_PAYLOAD, S_CRC} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               op_q, op_d;
    logic [7:0]               idx_q, idx_d;
    logic [7:0]               crc_q, crc_d;
    logic [8*MAX_PAYLOAD-1:0] buf_q, buf_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     draw_req_q, draw_req_d;
    logic [15:0]              edge_addr_q, edge_addr_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic [7:0]               cmd_opcode_q, cmd_opcode_d;
    logic [7:0]               cmd_len_q, cmd_len_d;
    logic [8*MAX_PAYLOAD-1:0] cmd_payload_q, cmd_payload_d;
    logic                     err_pulse_q, err_pulse_d;
    logic [2:0]               err_code_q, err_code_d;

    logic bad_len, last_payload, timeout_hit;

    // CRC-8, poly 0x07, MSB-first, one byte folded in per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign bad_len      = (rx_data < 8'd2) || (rx_data > MAX_LEN);
    assign last_payload = (idx_q == len_q - 8'd3);
    // A byte arriving in the expiry cycle keeps the packet alive.
    assign timeout_hit  = (state_q != S_HUNT) && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= S_HUNT;
            len_q         <= '0;
            op_q          <= '0;
            idx_q         <= '0;
            crc_q         <= '0;
            buf_q         <= '0;
            tmo_q         <= '0;
            draw_req_q    <= 1'b0;
            edge_addr_q   <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_opcode_q  <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            op_q          <= op_d;
            idx_q         <= idx_d;
            crc_q         <= crc_d;
            buf_q         <= buf_d;
            tmo_q         <= tmo_d;
            draw_req_q    <= draw_req_d;
            edge_addr_q   <= edge_addr_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_opcode_q  <= cmd_opcode_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT:    if (rx_valid && rx_data == SYNC) state_d = S_LEN;
            S_LEN:     if (rx_valid) state_d = bad_len ? S_HUNT : S_OP;
            S_OP:      if (rx_valid) state_d = (len_q > 8'd2) ? S_PAYLOAD : S_CRC;
            S_PAYLOAD: if (rx_valid && last_payload) state_d = S_CRC;
            S_CRC:     if (rx_valid) state_d = S_HUNT;
            default:   state_d = S_HUNT;
        endcase
        if (timeout_hit) state_d = S_HUNT;
    end

    always_comb begin
        len_d         = len_q;
        op_d          = op_q;
        idx_d         = idx_q;
        crc_d         = crc_q;
        buf_d         = buf_q;
        draw_req_d    = 1'b0;
        cmd_valid_d   = 1'b0;
        err_pulse_d   = 1'b0;
        edge_addr_d   = edge_addr_q;
        cmd_opcode_d  = cmd_opcode_q;
        cmd_len_d     = cmd_len_q;
        cmd_payload_d = cmd_payload_q;
        err_code_d    = err_code_q;
        if (state_q == S_HUNT || rx_valid || timeout_hit) tmo_d = '0;
        else tmo_d = tmo_q + TW'(1);
        case (state_q)
            // Idle in HUNT keeps the partial packet state cleared, so any abort discards it.
            S_HUNT: begin
                idx_d = '0;
                crc_d = '0;
                buf_d = '0;
            end
            S_LEN: if (rx_valid) begin
                if (bad_len) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_LEN;
                end else begin
                    len_d = rx_data;
                    crc_d = crc8_step(8'h00, rx_data);
                end
            end
            S_OP: if (rx_valid) begin
                op_d  = rx_data;
                crc_d = crc8_step(crc_q, rx_data);
            end
            S_PAYLOAD: if (rx_valid) begin
                for (int i = 0; i < MAX_PAYLOAD; i++)
                    if (idx_q == 8'(i)) buf_d[8*i +: 8] = rx_data;
                idx_d = idx_q + 8'd1;
                crc_d = crc8_step(crc_q, rx_data);
            end
            S_CRC: if (rx_valid) begin
                if (rx_data != crc_q) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_CRC;
                end else begin
                    cmd_valid_d   = 1'b1;
                    cmd_opcode_d  = op_q;
                    cmd_len_d     = len_q - 8'd2;
                    cmd_payload_d = buf_q;
                    if (op_q == OP_DRAW) begin
                        if (len_q != 8'd4) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_FMT;
                        end else if (draw_busy) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_BUSY;
                        end else begin
                            draw_req_d  = 1'b1;
                            edge_addr_d = {buf_q[7:0], buf_q[15:8]};
                        end
                    end
                end
            end
            default: ;
        endcase
        if (timeout_hit) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_TMO;
        end
    end

    assign draw_req_pulse = draw_req_q;
    assign edge_addr      = edge_addr_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_opcode     = cmd_opcode_q;
    assign cmd_len        = cmd_len_q;
    assign cmd_payload    = cmd_payload_q;
    assign err_pulse      = err_pulse_q;
    assign err_code       = err_code_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_cmd_rx_parser.sv
// Bench for cmd_rx_parser: directed scenarios plus randomized packets against a packet-level model.
// Every cycle with a pulse is snapshotted and compared with the model's expected event queue.
module tb_cmd_rx_parser;
    localparam int MP  = 4;
    localparam int TMO = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          draw_busy = 1'b0;
    logic          draw_req_pulse, cmd_valid, err_pulse;
    logic [15:0]   edge_addr;
    logic [7:0]    cmd_opcode, cmd_len;
    logic [8*MP-1:0] cmd_payload;
    logic [2:0]    err_code, dbg_state;

    always #5 clk = ~clk;

    cmd_rx_parser #(.MAX_PAYLOAD(MP), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .draw_busy(draw_busy),
        .draw_req_pulse(draw_req_pulse), .edge_addr(edge_addr), .cmd_valid(cmd_valid),
        .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
        .err_pulse(err_pulse), .err_code(err_code), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic        cv;
        logic        dr;
        logic        ep;
        logic [2:0]  ec;
        logic [7:0]  op;
        logic [7:0]  len;
        logic [31:0] pl;
        logic [15:0] ea;
    } ev_t;
    localparam int EW = $bits(ev_t);

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    int            obs_cyc_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cycle = 0;

    // Model of the published output registers.
    logic [7:0]  m_op = '0, m_len = '0;
    logic [31:0] m_pl = '0;
    logic [15:0] m_ea = '0;
    logic [2:0]  m_ec = '0;

    // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc_model(input int len, input logic [7:0] op, input logic [31:0] pl);
        logic [63:0] m;
        int np, nb;
        np = len - 2;
        m = {56'd0, 8'(len)};
        m = (m << 8) | {56'd0, op};
        for (int i = 0; i < np; i++) m = (m << 8) | {56'd0, pl[8*i +: 8]};
        m = m << 8;
        nb = (np + 3) * 8;
        for (int i = nb - 1; i >= 8; i--) if (m[i]) m = m ^ (64'h107 << (i - 8));
        return m[7:0];
    endfunction

    task automatic model_err(input logic [2:0] code);
        ev_t e;
        m_ec = code;
        e = '{cv: 1'b0, dr: 1'b0, ep: 1'b1, ec: m_ec, op: m_op, len: m_len, pl: m_pl, ea: m_ea};
        exp_q.push_back(e);
    endtask

    task automatic model_pkt(input int len, input logic [7:0] op, input logic [31:0] pl,
                             input logic [7:0] crc_xor, input logic busy);
        ev_t e;
        logic [31:0] vis;
        if (len < 2 || len > MP + 2) begin
            model_err(3'd2);
        end else if (crc_xor != 8'h00) begin
            model_err(3'd1);
        end else begin
            vis = '0;
            for (int i = 0; i < len - 2; i++) vis[8*i +: 8] = pl[8*i +: 8];
            m_op = op;
            m_len = 8'(len - 2);
            m_pl = vis;
            e = '{cv: 1'b1, dr: 1'b0, ep: 1'b0, ec: m_ec, op: m_op, len: m_len, pl: m_pl, ea: m_ea};
            if (op == 8'h06) begin
                if (len != 4) begin m_ec = 3'd5; e.ep = 1'b1; e.ec = m_ec; end
                else if (busy) begin m_ec = 3'd4; e.ep = 1'b1; e.ec = m_ec; end
                else begin m_ea = {vis[7:0], vis[15:8]}; e.dr = 1'b1; e.ea = m_ea; end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        m_op = '0; m_len = '0; m_pl = '0; m_ea = '0; m_ec = '0;
    endtask

    // One clock: drive a byte (or idle), then record any pulse cycle after the edge.
    task automatic tick(input logic v, input logic [7:0] d);
        ev_t e;
        rx_valid = v;
        rx_data = d;
        @(posedge clk);
        #1;
        cycle++;
        if (cmd_valid || draw_req_pulse || err_pulse) begin
            e = '{cv: cmd_valid, dr: draw_req_pulse, ep: err_pulse, ec: err_code,
                  op: cmd_opcode, len: cmd_len, pl: cmd_payload, ea: edge_addr};
            obs_q.push_back(e);
            obs_cyc_q.push_back(cycle);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] op, input logic [31:0] pl,
                            input logic [7:0] crc_xor, input logic busy, input int max_gap,
                            input int gap_idx, input int gap_len);
        logic [7:0] bytes[$];
        int g;
        draw_busy = busy;
        bytes.push_back(8'hAA);
        bytes.push_back(8'(len));
        if (len >= 2 && len <= MP + 2) begin
            bytes.push_back(op);
            for (int i = 0; i < len - 2; i++) bytes.push_back(pl[8*i +: 8]);
            bytes.push_back(crc_model(len, op, pl) ^ crc_xor);
        end
        for (int i = 0; i < bytes.size(); i++) begin
            g = (i == gap_idx) ? gap_len : int'($urandom_range(max_gap, 0));
            repeat (g) tick(1'b0, 8'h00);
            tick(1'b1, bytes[i]);
        end
        model_pkt(len, op, pl, crc_xor, busy);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        checks++; if (draw_req_pulse !== 1'b0) begin errors++; $display("FAIL reset draw_req_pulse: got %b want 0", draw_req_pulse); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset cmd_valid: got %b want 0", cmd_valid); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset err_pulse: got %b want 0", err_pulse); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL reset err_code: got %0d want 0", err_code); end
        checks++; if (edge_addr !== 16'h0) begin errors++; $display("FAIL reset edge_addr: got %h want 0000", edge_addr); end
        checks++; if ({cmd_opcode, cmd_len, cmd_payload} !== 48'h0) begin
            errors++; $display("FAIL reset cmd_fields: got %h %h %h want zeros", cmd_opcode, cmd_len, cmd_payload);
        end
        rst = 1'b0;
        tick(1'b0, 8'h00);
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_draw_basic();
        logic [EW-1:0] eo, ee;
        send_pkt(4, 8'h06, 32'h0000_0500, 8'h00, 1'b0, 0, -1, 0);
        repeat (2) tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL draw_basic count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL draw_basic event: got %h want %h", eo, ee); end
        end
        checks++; if (edge_addr !== 16'h0005) begin errors++; $display("FAIL draw_basic edge_addr: got %h want 0005", edge_addr); end
        checks++; if (cmd_opcode !== 8'h06 || cmd_len !== 8'd2) begin
            errors++; $display("FAIL draw_basic cmd: got op %h len %0d want op 06 len 2", cmd_opcode, cmd_len);
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_crc_err();
        logic [EW-1:0] eo, ee;
        send_pkt(4, 8'h06, 32'h0000_3412, 8'h01, 1'b0, 1, -1, 0);
        repeat (2) tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL crc_err count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL crc_err event: got %h want %h", eo, ee); end
        end
        checks++; if (edge_addr !== 16'h0005 || err_code !== 3'd1) begin
            errors++; $display("FAIL crc_err held: got edge %h code %0d want edge 0005 code 1", edge_addr, err_code);
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_bad_len();
        logic [EW-1:0] eo, ee;
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        send_pkt(7, 8'h00, 32'h0, 8'h00, 1'b0, 0, -1, 0);
        send_pkt(1, 8'h00, 32'h0, 8'h00, 1'b0, 0, -1, 0);
        send_pkt(0, 8'h00, 32'h0, 8'h00, 1'b0, 2, -1, 0);
        send_pkt(6, 8'h31, 32'hAADD_CCBB, 8'h00, 1'b0, 0, -1, 0);
        send_pkt(2, 8'h42, 32'h0, 8'h00, 1'b0, 1, -1, 0);
        repeat (2) tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bad_len count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL bad_len event: got %h want %h", eo, ee); end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        logic [EW-1:0] eo, ee;
        draw_busy = 1'b0;
        tick(1'b1, 8'hAA); tick(1'b1, 8'h04); tick(1'b1, 8'h06); tick(1'b1, 8'h00);
        repeat (TMO - 1) tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL timeout early: got %0d events want 0", obs_q.size()); end
        tick(1'b0, 8'h00);
        model_err(3'd3);
        // A byte in the expiry cycle must keep the packet alive.
        send_pkt(4, 8'h06, 32'h0000_0500, 8'h00, 1'b0, 0, 4, TMO - 1);
        repeat (2) tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL timeout event: got %h want %h", eo, ee); end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_draw_errors();
        logic [EW-1:0] eo, ee;
        send_pkt(4, 8'h06, 32'h0000_0403, 8'h00, 1'b1, 1, -1, 0);
        send_pkt(3, 8'h06, 32'h0000_0077, 8'h00, 1'b0, 0, -1, 0);
        send_pkt(2, 8'h06, 32'h0, 8'h00, 1'b0, 0, -1, 0);
        send_pkt(5, 8'h06, 32'h0011_2233, 8'h00, 1'b1, 0, -1, 0);
        repeat (2) tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL draw_err count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL draw_err event: got %h want %h", eo, ee); end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] eo, ee;
        send_pkt(4, 8'h06, 32'h0000_0500, 8'h00, 1'b0, 0, -1, 0);
        send_pkt(4, 8'h06, 32'h0000_0201, 8'h00, 1'b0, 0, -1, 0);
        tick(1'b0, 8'h00);
        checks++; if (obs_cyc_q.size() != 2 || obs_cyc_q[1] - obs_cyc_q[0] != 6) begin
            errors++; $display("FAIL b2b spacing: got %0d pulses (gap %0d) want 2 pulses gap 6",
                               obs_cyc_q.size(), (obs_cyc_q.size() >= 2) ? obs_cyc_q[1] - obs_cyc_q[0] : -1);
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL b2b event: got %h want %h", eo, ee); end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
        // Reset mid-payload: the packet vanishes without any strobe.
        tick(1'b1, 8'hAA); tick(1'b1, 8'h04); tick(1'b1, 8'h06); tick(1'b1, 8'h01);
        rst = 1'b1;
        tick(1'b1, 8'h02);
        rst = 1'b0;
        tick(1'b1, 8'h07);
        repeat (3) tick(1'b0, 8'h00);
        model_reset();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b reset events: got %0d want 0", obs_q.size()); end
        checks++; if ({edge_addr, err_code, cmd_opcode, cmd_len} !== 35'h0) begin
            errors++; $display("FAIL b2b reset outputs: got edge %h code %0d op %h len %0d want zeros", edge_addr, err_code, cmd_opcode, cmd_len);
        end
        send_pkt(4, 8'h06, 32'h0000_0201, 8'h00, 1'b0, 0, -1, 0);
        tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b after count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL b2b after event: got %h want %h", eo, ee); end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [EW-1:0] eo, ee;
        int r, len, nj;
        logic [7:0] op, cx, j;
        for (int n = 0; n < 40; n++) begin
            nj = int'($urandom_range(2, 0));
            for (int k = 0; k < nj; k++) begin
                j = 8'($urandom_range(255, 0));
                tick(1'b1, (j == 8'hAA) ? 8'h55 : j);
            end
            r = int'($urandom_range(9, 0));
            len = (r < 8) ? r : 4;
            op = ($urandom_range(1, 0) == 1) ? 8'h06 : 8'($urandom_range(255, 0));
            cx = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_pkt(len, op, $urandom, cx, 1'($urandom_range(1, 0)), 3, -1, 0);
        end
        repeat (2) tick(1'b0, 8'h00);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front();
            checks++; if (eo !== ee) begin errors++; $display("FAIL random event: got %h want %h", eo, ee); end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_draw_basic();
        test_crc_err();
        test_bad_len();
        test_timeout();
        test_draw_errors();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
